// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial x - y - borrow_in, LSB first, one bit per clock.
// Operands are accepted on a valid/ready handshake while idle. The result is
// presented on a second valid/ready handshake after WIDTH shift cycles.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed 'overflow'
// output, registered alongside borrow_out.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// SHIFT | processing one bit per cycle, WIDTH cycles
// DONE  | result valid, waiting for out_ready
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_sr_q, x_sr_d;
    logic [WIDTH-1:0] y_sr_q, y_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic a_bit, b_bit, d_bit, c_next;

    // Single-bit subtract slice on the current LSBs and the running borrow
    always_comb begin
        a_bit  = x_sr_q[0];
        b_bit  = y_sr_q[0];
        d_bit  = a_bit ^ b_bit ^ c_q;
        c_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_q);
    end

    // Next-state and datapath update; the result register shifts in at the
    // MSB, while diff/borrow_out only change when a result completes
    always_comb begin
        state_d      = state_q;
        x_sr_d       = x_sr_q;
        y_sr_d       = y_sr_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        c_d          = c_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_sr_d  = x;
                    y_sr_d  = y;
                    c_d     = borrow_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                x_sr_d = x_sr_q >> 1;
                y_sr_d = y_sr_q >> 1;
                c_d    = c_next;
                res_d  = {d_bit, {(WIDTH-1){1'b0}}} | (res_q >> 1);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d       = res_d;
                    borrow_out_d = c_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // borrow into the MSB xor borrow out of the MSB
                    ovf_d        = c_q ^ c_next;
`endif
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_sr_q       <= '0;
            y_sr_q       <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            c_q          <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_sr_q       <= x_sr_d;
            y_sr_q       <= y_sr_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            c_q          <= c_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    // Handshake flags decode straight from the state register
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        overflow   = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table, hand-written handshake
// and reset sequences, and randomized operands against an arithmetic model.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [WIDTH-1:0] vx;
        logic [WIDTH-1:0] vy;
        logic             vb;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_borrow;
        logic             exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic void model(input logic [WIDTH-1:0] mx, input logic [WIDTH-1:0] my,
                                  input logic mb, output logic [WIDTH-1:0] md,
                                  output logic mbo, output logic movf);
        longint ux, uy, ub, sx, sy, sr;
        ux   = longint'(mx);
        uy   = longint'(my);
        ub   = longint'(mb);
        md   = WIDTH'(ux - uy - ub);
        mbo  = (ux < uy + ub);
        sx   = (mx[WIDTH-1]) ? ux - (longint'(1) << WIDTH) : ux;
        sy   = (my[WIDTH-1]) ? uy - (longint'(1) << WIDTH) : uy;
        sr   = sx - sy - ub;
        movf = (sr < -(longint'(1) << (WIDTH-1))) || (sr > ((longint'(1) << (WIDTH-1)) - 1));
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] sx, input logic [WIDTH-1:0] sy, input logic sb);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        x         = sx;
        y         = sy;
        borrow_in = sb;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        x         = WIDTH'($urandom);
        y         = WIDTH'($urandom);
        borrow_in = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_hs_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_hs_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input string name, input logic [WIDTH-1:0] vx, input logic [WIDTH-1:0] vy,
                           input logic vb, input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        int lat;
        start_op(vx, vy, vb);
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'(WIDTH));
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_borrow"}, 32'(borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({name, "_overflow"}, 32'(overflow), 32'(eo));
`else
        if (eo !== eo) check({name, "_overflow_x"}, 32'(eo), 32'd0);
`endif
        check({name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        handshake(name);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        logic [WIDTH-1:0] rx, ry, md;
        logic rb, mbo, movf;

        vecs[0] = '{8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].vx, vecs[i].vy, vecs[i].vb,
                    vecs[i].exp_diff, vecs[i].exp_borrow, vecs[i].exp_ovf);
        end

        // Backpressure: result held, in_valid ignored while DONE
        start_op(8'h10, 8'h03, 1'b0);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'(WIDTH));
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_diff", 32'(diff), 32'h0D);
            check("bp_borrow", 32'(borrow_out), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake("bp");
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_idle_in_ready", 32'(in_ready), 32'd1);
            check("bp_idle_out_valid", 32'(out_valid), 32'd0);
            check("bp_idle_diff_held", 32'(diff), 32'h0D);
        end

        // Operand change right after the accept edge
        start_op(8'h20, 8'h01, 1'b0);
        x = 8'hFF;
        y = 8'hFF;
        wait_done(lat);
        check("opchg_latency", 32'(lat), 32'(WIDTH));
        check("opchg_diff", 32'(diff), 32'h1F);
        check("opchg_borrow", 32'(borrow_out), 32'd0);
        handshake("opchg");

        // Reset in the 4th SHIFT cycle with a nonzero previous result
        run_vec("pre_rst", 8'hC3, 8'h01, 1'b0, 8'hC2, 1'b0, 1'b0);
        start_op(8'h77, 8'h11, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_borrow", 32'(borrow_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (WIDTH + 2) begin
            @(posedge clk); #1;
            check("postrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_vec("postrst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

        // Randomized operands against the model
        for (int i = 0; i < 40; i++) begin
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            rb = 1'($urandom);
            if (i == 0) begin rx = '0; ry = '1; end
            if (i == 1) begin rx = '1; ry = '0; end
            model(rx, ry, rb, md, mbo, movf);
            run_vec($sformatf("rand%0d", i), rx, ry, rb, md, mbo, movf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing `x - y - borrow_in` one bit per clock, LSB first, behind valid/ready handshakes on both sides. It is the inverse-operation companion to the combinational `adder` datapath. It trades WIDTH cycles of latency for a single-bit arithmetic slice and sits in the same arithmetic test flow, driven and checked by a self-checking bench.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block idle and able to accept operands.
- `x`  input  WIDTH  minuend.
- `y`  input  WIDTH  subtrahend.
- `borrow_in`  input  1  incoming borrow.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `diff`  output  WIDTH  `(x - y - borrow_in) mod 2^WIDTH`.
- `borrow_out`  output  1  set when `x < y + borrow_in` (unsigned).
- `overflow`  output  1  signed overflow; present only with `SERIAL_SUB_OVERFLOW_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- `in_ready` is 1 exactly in IDLE and is decoded from the state register.
- IDLE with `in_valid`=1 (accept):
  - load `x`, `y` into shift registers;
  - load the borrow register from `borrow_in`;
  - clear the bit counter;
  - go to SHIFT.
- SHIFT, each cycle, with `a` = x_sr[0], `b` = y_sr[0], `c` = borrow register:
  - d = a^b^c;
  - c' = (~a&b) | (~(a^b)&c);
  - shift x_sr and y_sr right by 1;
  - shift d into the result register at the MSB, shifting it right;
  - increment the counter.
- On the WIDTH-th SHIFT cycle (counter = WIDTH-1), go to DONE.
- DONE:
  - `out_valid`=1; `diff` and `borrow_out` are held stable.
  - `out_ready`=1 returns the FSM to IDLE.
  - `out_ready`=0 holds DONE indefinitely.
- `in_valid` is ignored outside IDLE. Operands are sampled only on the accept edge; later changes on `x`/`y`/`borrow_in` have no effect.
- After the output handshake, `diff`/`borrow_out` keep their last values until the next result completes.
- Reset (asserted at any time, including mid-SHIFT or in DONE):
  - `out_valid`=0, `diff`=0, `borrow_out`=0, `overflow`=0;
  - FSM to IDLE, so `in_ready`=1 while `rst_n` is low;
  - any in-flight operation is discarded.

## Timing
- Accept at rising edge N. SHIFT occupies cycles N+1..N+WIDTH. `out_valid` rises after edge N+WIDTH. Latency is WIDTH cycles accept-to-valid.
- Output handshake at edge M (out_valid & out_ready) → `out_valid`=0 and `in_ready`=1 from M+1.
- There is no same-cycle bypass: `in_ready` is 0 during the handshake cycle.
- Minimum issue interval is WIDTH+2 cycles.
- No combinational path from any input to any output.

## Configuration
- `SERIAL_SUB_OVERFLOW_EN` defined:
  - port `overflow` exists.
  - Registered alongside `borrow_out`: overflow = (borrow into MSB) XOR (borrow out of MSB), captured on the last SHIFT cycle.
  - Meaning: signed two's-complement `x - y - borrow_in` is not representable in WIDTH bits.
  - Valid with `out_valid`; reset value 0.
- Undefined: no `overflow` port and no associated logic; all other behaviour is identical.

## Test plan
- WIDTH=8, x=3, y=1, borrow_in=0, out_ready=1 → diff=0x02, borrow_out=0; `out_valid` first high exactly 8 cycles after accept; `in_ready` high again 2 cycles after accept+8.
- x=0x00, y=0x01, borrow_in=0 → diff=0xFF, borrow_out=1. Also x=0x05, y=0x05, borrow_in=1 → diff=0xFF, borrow_out=1.
- Backpressure: complete x=0x10, y=0x03; hold out_ready=0 for 5 cycles while toggling in_valid with other operands → `out_valid`=1 and diff=0x0D are stable throughout, in_ready=0, no second accept; raise out_ready → single handshake, back to IDLE.
- Operand change after accept: accept x=0x20, y=0x01, then drive x=0xFF, y=0xFF on the next cycle → diff=0x1F, borrow_out=0.
- Reset mid-operation: assert rst_n=0 in the 4th SHIFT cycle → out_valid=0, diff=0, borrow_out=0, in_ready=1 immediately; after release, x=9, y=4 → diff=0x05.
- With `SERIAL_SUB_OVERFLOW_EN`:
  - x=0x80, y=0x01, borrow_in=0 → diff=0x7F, borrow_out=0, overflow=1.
  - x=0x7F, y=0xFF → diff=0x80, borrow_out=1, overflow=1.
  - x=0x05, y=0x03 → overflow=0.
